calc_token_engine: RTL and testbench

Responder end of the calculator token interface. It accepts 32-bit tokens strobed by the control state machine and evaluates the infix expression using operator precedence, with an operand stack and an operator stack. It drops `calc_ready` while busy and presents the result on `calc_answer` when the `=` token arrives. It sits between the control FSM and the VGA answer path.

---
 rtl/calc_token_engine_if.sv | 27 ++
 rtl/calc_token_engine.sv | 269 ++++++++++++++++++++++++++
 tb/tb_calc_token_engine.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_token_engine_if.sv
// Token handshake between the control FSM (master) and calc_token_engine (slave).
interface calc_token_engine_if;
    logic        strobe;
    logic [31:0] token;
    logic        calc_ready;
    logic [31:0] calc_answer;
    logic        answer_valid;
    logic        error;

    modport master (
        output strobe,
        output token,
        input  calc_ready,
        input  calc_answer,
        input  answer_valid,
        input  error
    );

    modport slave (
        input  strobe,
        input  token,
        output calc_ready,
        output calc_answer,
        output answer_valid,
        output error
    );
endinterface

// File: rtl/calc_token_engine.sv
// Infix calculator engine with operand/operator stacks and precedence reduction.
// Define CALC_DIV_EN to build the 32-cycle restoring divider (DIVIDE state).
module calc_token_engine #(
    parameter int DEPTH = 8
) (
    input  logic          clock,
    input  logic          reset,
    calc_token_engine_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0] TOK_CLR = 32'h8000_000F;
    localparam logic [1:0]  OP_DIV  = 2'd3;

`ifdef CALC_DIV_EN
    typedef enum logic [2:0] {
        S_IDLE, S_ACCEPT, S_REDUCE, S_DIVIDE, S_FINISH, S_DONE
    } state_e;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_ACCEPT, S_REDUCE, S_FINISH, S_DONE
    } state_e;
`endif

    state_e        state_q, state_d;
    logic [31:0]   tok_q, tok_d;
    logic [31:0]   ans_q, ans_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic [31:0]   opnd_q [DEPTH];
    logic [31:0]   opnd_d [DEPTH];
    logic [1:0]    oper_q [DEPTH];
    logic [1:0]    oper_d [DEPTH];
    logic [CW-1:0] nd_cnt_q, nd_cnt_d;
    logic [CW-1:0] op_cnt_q, op_cnt_d;

`ifdef CALC_DIV_EN
    logic [31:0]   div_rem_q, div_rem_d;
    logic [31:0]   div_quo_q, div_quo_d;
    logic [31:0]   div_den_q, div_den_d;
    logic [4:0]    div_cnt_q, div_cnt_d;
    logic [32:0]   div_trial;
    logic          div_ge;
`endif

    logic [PW-1:0] nd_top, nd_sec, op_top, op_sec;
    logic          is_eq, is_op, is_div, op_ok;
    logic [1:0]    in_op;
    state_e        nxt;

    function automatic logic [31:0] alu(
        input logic [1:0]  op,
        input logic [31:0] a,
        input logic [31:0] b
    );
        unique case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a * b;
            default: return 32'd0;
        endcase
    endfunction

    // Next step once a reduction has landed; cnt is the operator count left.
    function automatic state_e after_reduce(
        input logic [CW-1:0] cnt,
        input logic [1:0]    top,
        input logic          eq,
        input logic [1:0]    op
    );
        if (cnt == '0) return eq ? S_FINISH : S_DONE;
        if (eq || top[1] >= op[1]) return S_REDUCE;
        return S_DONE;
    endfunction

    always_comb begin
        state_d  = state_q;
        tok_d    = tok_q;
        ans_d    = ans_q;
        valid_d  = valid_q;
        err_d    = err_q;
        opnd_d   = opnd_q;
        oper_d   = oper_q;
        nd_cnt_d = nd_cnt_q;
        op_cnt_d = op_cnt_q;
        nxt      = S_IDLE;
        nd_top   = PW'(nd_cnt_q - CW'(1));
        nd_sec   = PW'(nd_cnt_q - CW'(2));
        op_top   = PW'(op_cnt_q - CW'(1));
        op_sec   = PW'(op_cnt_q - CW'(2));
        is_eq    = tok_q[3:0] == 4'hE;
        is_op    = tok_q[3:0] >= 4'hA && tok_q[3:0] <= 4'hD;
        in_op    = 2'(tok_q[3:0] - 4'hA);
`ifdef CALC_DIV_EN
        op_ok     = is_op;
        is_div    = oper_q[op_top] == OP_DIV;
        div_rem_d = div_rem_q;
        div_quo_d = div_quo_q;
        div_den_d = div_den_q;
        div_cnt_d = div_cnt_q;
        div_trial = {div_rem_q, div_quo_q[31]} - {1'b0, div_den_q};
        div_ge    = ~div_trial[32];
`else
        op_ok     = is_op && in_op != OP_DIV;
        is_div    = 1'b0;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (bus.strobe) begin
                    tok_d   = bus.token;
                    valid_d = 1'b0;
                    state_d = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                state_d = S_DONE;
                if (tok_q == TOK_CLR) begin
                    nd_cnt_d = '0;
                    op_cnt_d = '0;
                    ans_d    = '0;
                    err_d    = 1'b0;
                    valid_d  = 1'b0;
                end else if (err_q) begin
                    state_d = S_DONE;
                end else if (!tok_q[31]) begin
                    if (nd_cnt_q == CW'(DEPTH)) begin
                        err_d = 1'b1;
                    end else begin
                        opnd_d[nd_cnt_q[PW-1:0]] = tok_q;
                        nd_cnt_d = nd_cnt_q + CW'(1);
                    end
                end else if (is_eq) begin
                    state_d = (op_cnt_q != '0) ? S_REDUCE : S_FINISH;
                end else if (op_ok) begin
                    if (op_cnt_q != '0 && oper_q[op_top][1] >= in_op[1]) begin
                        state_d = S_REDUCE;
                    end else if (op_cnt_q == CW'(DEPTH)) begin
                        err_d = 1'b1;
                    end else begin
                        oper_d[op_cnt_q[PW-1:0]] = in_op;
                        op_cnt_d = op_cnt_q + CW'(1);
                    end
                end else begin
                    err_d = 1'b1;
                end
            end
            S_REDUCE: begin
                if (nd_cnt_q < CW'(2)) begin
                    err_d    = 1'b1;
                    nd_cnt_d = '0;
                    op_cnt_d = '0;
                    state_d  = S_DONE;
                end else begin
                    op_cnt_d = op_cnt_q - CW'(1);
                    nd_cnt_d = nd_cnt_q - CW'(1);
                    if (is_div) begin
`ifdef CALC_DIV_EN
                        div_quo_d = opnd_q[nd_sec];
                        div_den_d = opnd_q[nd_top];
                        div_rem_d = '0;
                        div_cnt_d = '0;
                        state_d   = S_DIVIDE;
`endif
                    end else begin
                        opnd_d[nd_sec] = alu(oper_q[op_top], opnd_q[nd_sec],
                                             opnd_q[nd_top]);
                        nxt = after_reduce(op_cnt_q - CW'(1), oper_q[op_sec],
                                           is_eq, in_op);
                        state_d = nxt;
                        if (nxt == S_DONE) begin
                            oper_d[op_top] = in_op;
                            op_cnt_d = op_cnt_q;
                        end
                    end
                end
            end
`ifdef CALC_DIV_EN
            S_DIVIDE: begin
                div_quo_d = {div_quo_q[30:0], div_ge};
                div_rem_d = div_ge ? div_trial[31:0]
                                   : {div_rem_q[30:0], div_quo_q[31]};
                div_cnt_d = div_cnt_q + 5'd1;
                if (div_cnt_q == 5'd31) begin
                    // Zero divisor: result forced to 0, reduction carries on.
                    if (div_den_q == '0) begin
                        opnd_d[nd_top] = '0;
                        err_d = 1'b1;
                    end else begin
                        opnd_d[nd_top] = {div_quo_q[30:0], div_ge};
                    end
                    nxt = after_reduce(op_cnt_q, oper_q[op_top], is_eq, in_op);
                    state_d = nxt;
                    if (nxt == S_DONE) begin
                        oper_d[op_cnt_q[PW-1:0]] = in_op;
                        op_cnt_d = op_cnt_q + CW'(1);
                    end
                end
            end
`endif
            S_FINISH: begin
                if (nd_cnt_q == CW'(1)) begin
                    ans_d   = opnd_q[0];
                    valid_d = 1'b1;
                end else begin
                    ans_d = '0;
                    err_d = 1'b1;
                end
                nd_cnt_d = '0;
                op_cnt_d = '0;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A clear offered while busy preempts whatever is in flight.
        if (state_q != S_IDLE && bus.strobe && bus.token == TOK_CLR) begin
            tok_d   = TOK_CLR;
            state_d = S_ACCEPT;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            tok_q    <= '0;
            ans_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            nd_cnt_q <= '0;
            op_cnt_q <= '0;
`ifdef CALC_DIV_EN
            div_rem_q <= '0;
            div_quo_q <= '0;
            div_den_q <= '0;
            div_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            tok_q    <= tok_d;
            ans_q    <= ans_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            nd_cnt_q <= nd_cnt_d;
            op_cnt_q <= op_cnt_d;
`ifdef CALC_DIV_EN
            div_rem_q <= div_rem_d;
            div_quo_q <= div_quo_d;
            div_den_q <= div_den_d;
            div_cnt_q <= div_cnt_d;
`endif
        end
    end

    always_ff @(posedge clock) begin
        opnd_q <= opnd_d;
        oper_q <= oper_d;
    end

    assign bus.calc_ready   = (state_q == S_IDLE);
    assign bus.calc_answer  = ans_q;
    assign bus.answer_valid = valid_q;
    assign bus.error        = err_q;
endmodule

// File: tb/tb_calc_token_engine.sv
// Directed and randomized checks of calc_token_engine against an expression model.
module tb_calc_token_engine;
    localparam logic [31:0] T_ADD = 32'h8000_000A;
    localparam logic [31:0] T_SUB = 32'h8000_000B;
    localparam logic [31:0] T_MUL = 32'h8000_000C;
    localparam logic [31:0] T_DIV = 32'h8000_000D;
    localparam logic [31:0] T_EQ  = 32'h8000_000E;
    localparam logic [31:0] T_CLR = 32'h8000_000F;
`ifdef CALC_DIV_EN
    localparam int MAXOP = 3;
`else
    localparam int MAXOP = 2;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   busy;

    calc_token_engine_if bus();

    calc_token_engine #(.DEPTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Offer one token when ready; returns cycles calc_ready stayed low.
    task automatic send(input logic [31:0] t, output int cyc);
        int w;
        w = 0;
        while (bus.calc_ready !== 1'b1 && w < 500) begin
            @(negedge clock);
            w++;
        end
        bus.strobe = 1'b1;
        bus.token  = t;
        @(negedge clock);
        bus.strobe = 1'b0;
        cyc = 0;
        while (bus.calc_ready !== 1'b1 && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
        check("ready_timeout", 32'(cyc < 200), 32'd1);
    endtask

    task automatic tok(input logic [31:0] t);
        int c;
        send(t, c);
    endtask

    function automatic logic [31:0] num(input int unsigned v);
        return {1'b0, v[30:0]};
    endfunction

    function automatic logic [31:0] rnd_num();
        unsigned_pick: begin
            int unsigned p;
            p = $urandom_range(0, 2);
            if (p == 0) return 32'($urandom_range(0, 20));
            if (p == 1) return {1'b0, 31'($urandom)};
            return 32'($urandom_range(0, 65535));
        end
    endfunction

    // Precedence by term folding: x and / bind into terms, terms summed left to right.
    function automatic logic [31:0] model(input logic [31:0] n[$],
                                          input logic [1:0] o[$]);
        logic [31:0] acc, term;
        logic        neg;
        acc  = '0;
        neg  = 1'b0;
        term = n[0];
        for (int i = 0; i < o.size(); i++) begin
            if (o[i] == 2'd2) term = term * n[i+1];
            else if (o[i] == 2'd3) term = term / n[i+1];
            else begin
                acc  = neg ? acc - term : acc + term;
                neg  = (o[i] == 2'd1);
                term = n[i+1];
            end
        end
        return neg ? acc - term : acc + term;
    endfunction

    initial begin
        logic [31:0] ns[$];
        logic [1:0]  os[$];
        logic [1:0]  op;
        int          nops;

        bus.strobe = 1'b0;
        bus.token  = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_ready", 32'(bus.calc_ready), 32'd1);
        check("rst_answer", bus.calc_answer, 32'd0);
        check("rst_valid", 32'(bus.answer_valid), 32'd0);
        check("rst_error", 32'(bus.error), 32'd0);

        send(num(3), busy);
        check("num_busy", busy, 32'd2);
        tok(T_ADD); tok(num(4)); tok(T_MUL); tok(num(2));
        send(T_EQ, busy);
        check("prec_eq_busy", busy, 32'd5);
        check("prec_answer", bus.calc_answer, 32'd11);
        check("prec_valid", 32'(bus.answer_valid), 32'd1);
        check("prec_error", 32'(bus.error), 32'd0);

        tok(num(10)); tok(T_SUB); tok(num(3));
        send(T_SUB, busy);
        check("assoc_op_busy", busy, 32'd3);
        tok(num(2)); tok(T_EQ);
        check("assoc_answer", bus.calc_answer, 32'd5);
        tok(num(0)); tok(T_SUB); tok(num(1)); tok(T_EQ);
        check("wrap_answer", bus.calc_answer, 32'hFFFF_FFFF);

        // clear arriving one cycle into an '=' evaluation
        tok(num(3)); tok(T_ADD); tok(num(4)); tok(T_MUL); tok(num(2));
        bus.strobe = 1'b1;
        bus.token  = T_EQ;
        @(negedge clock);
        bus.token  = T_CLR;
        @(negedge clock);
        bus.strobe = 1'b0;
        busy = 0;
        while (bus.calc_ready !== 1'b1 && busy < 50) begin
            @(negedge clock);
            busy++;
        end
        check("clr_reduce_ready", 32'(busy <= 3), 32'd1);
        check("clr_reduce_answer", bus.calc_answer, 32'd0);
        check("clr_reduce_error", 32'(bus.error), 32'd0);

        tok(num(7)); tok(T_EQ);
        check("single_answer", bus.calc_answer, 32'd7);
        tok(num(1));
        check("valid_drop", 32'(bus.answer_valid), 32'd0);
        check("answer_hold", bus.calc_answer, 32'd7);
        tok(T_EQ);
        check("single2_answer", bus.calc_answer, 32'd1);

        // strobe held with a number while busy must not push it
        bus.strobe = 1'b1;
        bus.token  = num(5);
        @(negedge clock);
        bus.token  = num(9);
        @(negedge clock);
        bus.strobe = 1'b0;
        @(negedge clock);
        tok(T_EQ);
        check("held_answer", bus.calc_answer, 32'd5);
        check("held_error", 32'(bus.error), 32'd0);

`ifdef CALC_DIV_EN
        tok(num(100)); tok(T_DIV); tok(num(7));
        send(T_EQ, busy);
        check("div_eq_busy", busy, 32'd36);
        check("div_answer", bus.calc_answer, 32'd14);
        tok(num(100)); tok(T_DIV); tok(num(7));
        send(T_ADD, busy);
        check("div_op_busy", busy, 32'd35);
        tok(num(1)); tok(T_EQ);
        check("div_add_answer", bus.calc_answer, 32'd15);
        tok(num(7)); tok(T_DIV); tok(num(0)); tok(T_EQ);
        check("div0_error", 32'(bus.error), 32'd1);
        check("div0_answer", bus.calc_answer, 32'd0);
        tok(T_CLR);
        check("div0_clr_error", 32'(bus.error), 32'd0);
        tok(num(9)); tok(T_DIV); tok(num(2)); tok(T_EQ);
        check("div_floor", bus.calc_answer, 32'd4);
        tok(num(100)); tok(T_DIV); tok(num(7));
        bus.strobe = 1'b1;
        bus.token  = T_EQ;
        @(negedge clock);
        bus.strobe = 1'b0;
        repeat (4) @(negedge clock);
        bus.strobe = 1'b1;
        bus.token  = T_CLR;
        @(negedge clock);
        bus.strobe = 1'b0;
        busy = 0;
        while (bus.calc_ready !== 1'b1 && busy < 50) begin
            @(negedge clock);
            busy++;
        end
        check("clr_div_ready", 32'(busy <= 3), 32'd1);
        check("clr_div_answer", bus.calc_answer, 32'd0);
        check("clr_div_error", 32'(bus.error), 32'd0);
`else
        tok(num(100)); tok(T_DIV);
        check("nodiv_error", 32'(bus.error), 32'd1);
        tok(T_CLR);
        check("nodiv_clr", 32'(bus.error), 32'd0);
`endif

        tok(num(2));
        for (int i = 0; i < 8; i++) begin
            tok(T_MUL);
            tok(num(2));
        end
        tok(T_EQ);
        check("chain_answer", bus.calc_answer, 32'd512);
        check("chain_error", 32'(bus.error), 32'd0);
        for (int i = 0; i < 8; i++) tok(num(i + 1));
        check("full_error", 32'(bus.error), 32'd0);
        tok(num(9));
        check("ovf_error", 32'(bus.error), 32'd1);
        send(T_EQ, busy);
        check("err_eq_busy", busy, 32'd2);
        check("err_eq_answer", bus.calc_answer, 32'd512);
        tok(T_CLR);
        check("ovf_clr_answer", bus.calc_answer, 32'd0);

        tok(32'h8000_0005);
        check("unknown_error", 32'(bus.error), 32'd1);
        tok(T_CLR);
        tok(T_ADD); tok(T_ADD);
        check("underflow_error", 32'(bus.error), 32'd1);
        tok(T_CLR);
        tok(num(4)); tok(T_EQ);
        check("four_answer", bus.calc_answer, 32'd4);
        tok(num(5)); tok(num(6)); tok(T_EQ);
        check("two_left_error", 32'(bus.error), 32'd1);
        check("two_left_answer", bus.calc_answer, 32'd0);
        tok(T_CLR);

        tok(num(5)); tok(T_ADD);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("midrst_ready", 32'(bus.calc_ready), 32'd1);
        check("midrst_answer", bus.calc_answer, 32'd0);
        tok(num(2)); tok(T_EQ);
        check("midrst_eval", bus.calc_answer, 32'd2);

        for (int k = 0; k < 25; k++) begin
            ns.delete();
            os.delete();
            nops = $urandom_range(1, 4);
            ns.push_back(rnd_num());
            for (int i = 0; i < nops; i++) begin
                op = 2'($urandom_range(0, MAXOP));
                os.push_back(op);
                if (op == 2'd3) ns.push_back(32'($urandom_range(1, 40)));
                else ns.push_back(rnd_num());
            end
            tok(ns[0]);
            for (int i = 0; i < nops; i++) begin
                tok(T_ADD + 32'(os[i]));
                tok(ns[i+1]);
            end
            tok(T_EQ);
            check("rand_answer", bus.calc_answer, model(ns, os));
            check("rand_valid", 32'(bus.answer_valid), 32'd1);
            check("rand_error", 32'(bus.error), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
